sample_tx_arbiter: RTL and testbench

- Round-robin scheduler that drains the five sample queues (din, adc0, adc1, curr0, curr1) into the UART tx byte queue.
- Each sample is emitted as a 2-byte frame: header byte (source id + data[11:8]) then data[7:0].
- Sits between the sample queues and tx_queue; replaces ad-hoc sample forwarding in control.

---
 rtl/sample_tx_arbiter.sv | 115 +++++++++++
 tb/tb_sample_tx_arbiter.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/sample_tx_arbiter.sv
// Round-robin scheduler draining five sample queues into the UART tx byte queue.
// Each sample is sent as a header byte {id, 0, data[11:8]} followed by data[7:0].
module sample_tx_arbiter #(
  parameter int unsigned NBITS = 12,
  parameter int unsigned DBITS = 8,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [4:0]       mask,
  input  logic [4:0]       em_src,
  input  logic [DBITS-1:0] in_din,
  input  logic [NBITS-1:0] in_adc0,
  input  logic [NBITS-1:0] in_adc1,
  input  logic [NBITS-1:0] in_cadc0,
  input  logic [NBITS-1:0] in_cadc1,
  output logic [4:0]       pp_src,
  input  logic             tx_full,
  output logic [7:0]       out_write,
  output logic             ld_write,
  output logic             busy,
  output logic [2:0]       grant_id,
  output logic [CNT_W-1:0] frame_cnt
);

  typedef enum logic [1:0] {StIdle, StPop, StHdr, StLow} state_e;

  state_e           state_q, state_d;
  logic [2:0]       grant_q;
  logic [2:0]       last_q;
  logic [NBITS-1:0] sample_q;
  logic [CNT_W-1:0] cnt_q;

  logic [4:0]       req;
  logic             hit;
  logic [2:0]       hit_id;
  logic [NBITS-1:0] head;

  assign req = mask & ~em_src & {5{en}};

  // Search starts just after the last grant, so the source just served comes last.
  always_comb begin
    hit    = 1'b0;
    hit_id = '0;
    for (int k = 1; k <= 5; k++) begin
      logic [2:0] idx;
      idx = 3'((int'(last_q) + k) % 5);
      if (!hit && req[idx]) begin
        hit    = 1'b1;
        hit_id = idx;
      end
    end
  end

  always_comb begin
    head = '0;
    unique case (grant_q)
      3'd0:    head = in_cadc1;
      3'd1:    head = in_cadc0;
      3'd2:    head = in_adc1;
      3'd3:    head = in_adc0;
      3'd4:    head = NBITS'(in_din);
      default: head = '0;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    pp_src    = '0;
    ld_write  = 1'b0;
    out_write = '0;
    unique case (state_q)
      StIdle: if (hit) state_d = StPop;
      StPop: begin
        pp_src[grant_q] = 1'b1;
        state_d         = StHdr;
      end
      StHdr: begin
        out_write = {grant_q, 1'b0, sample_q[11:8]};
        ld_write  = ~tx_full;
        if (!tx_full) state_d = StLow;
      end
      StLow: begin
        out_write = sample_q[7:0];
        ld_write  = ~tx_full;
        if (!tx_full) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      grant_q  <= '0;
      last_q   <= 3'd4;
      sample_q <= '0;
      cnt_q    <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == StIdle && hit) begin
        grant_q <= hit_id;
        last_q  <= hit_id;
      end
      if (state_q == StPop) sample_q <= head;
      if (state_q == StLow && !tx_full) cnt_q <= cnt_q + 1'b1;
    end
  end

  assign busy      = (state_q != StIdle);
  assign grant_id  = grant_q;
  assign frame_cnt = cnt_q;

endmodule

// File: tb/tb_sample_tx_arbiter.sv
// Directed bench for sample_tx_arbiter: framing, round-robin order, stalls, masking, reset.
// A narrow frame counter is used so the wrap-around is reachable quickly.
module tb_sample_tx_arbiter;

  localparam int unsigned NBITS = 12;
  localparam int unsigned DBITS = 8;
  localparam int unsigned CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             en;
  logic [4:0]       mask;
  logic [4:0]       em_src;
  logic [DBITS-1:0] in_din;
  logic [NBITS-1:0] in_adc0, in_adc1, in_cadc0, in_cadc1;
  logic [4:0]       pp_src;
  logic             tx_full;
  logic [7:0]       out_write;
  logic             ld_write;
  logic             busy;
  logic [2:0]       grant_id;
  logic [CNT_W-1:0] frame_cnt;

  int errors = 0;
  int checks = 0;

  // Hand-computed frames per source id for the fixed queue heads below.
  logic [7:0] exp_hdr [5];
  logic [7:0] exp_low [5];

  sample_tx_arbiter #(
    .NBITS(NBITS),
    .DBITS(DBITS),
    .CNT_W(CNT_W)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .mask     (mask),
    .em_src   (em_src),
    .in_din   (in_din),
    .in_adc0  (in_adc0),
    .in_adc1  (in_adc1),
    .in_cadc0 (in_cadc0),
    .in_cadc1 (in_cadc1),
    .pp_src   (pp_src),
    .tx_full  (tx_full),
    .out_write(out_write),
    .ld_write (ld_write),
    .busy     (busy),
    .grant_id (grant_id),
    .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // From IDLE with a request pending and tx_full low: one full frame.
  task automatic frame(input int id, input int cnt_after);
    step();
    check("pop_grant", 32'(grant_id), 32'(id));
    check("pop_strobe", 32'(pp_src), 32'(5'b00001 << id));
    step();
    check("hdr_byte", 32'(out_write), 32'(exp_hdr[id]));
    check("hdr_ld", 32'(ld_write), 32'd1);
    check("hdr_nopop", 32'(pp_src), 32'd0);
    step();
    check("low_byte", 32'(out_write), 32'(exp_low[id]));
    check("low_ld", 32'(ld_write), 32'd1);
    step();
    check("idle_busy", 32'(busy), 32'd0);
    check("frame_cnt", 32'(frame_cnt), 32'(cnt_after));
  endtask

  initial begin
    in_cadc1 = 12'h789;
    in_cadc0 = 12'h456;
    in_adc1  = 12'h123;
    in_adc0  = 12'hABC;
    in_din   = 8'h5A;
    exp_hdr[0] = 8'h07; exp_low[0] = 8'h89;
    exp_hdr[1] = 8'h24; exp_low[1] = 8'h56;
    exp_hdr[2] = 8'h41; exp_low[2] = 8'h23;
    exp_hdr[3] = 8'h6A; exp_low[3] = 8'hBC;
    exp_hdr[4] = 8'h80; exp_low[4] = 8'h5A;

    rst_n   = 1'b0;
    en      = 1'b1;
    mask    = 5'h1F;
    em_src  = 5'h1F;
    tx_full = 1'b0;
    step();
    step();
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_out", 32'(out_write), 32'd0);
    check("rst_ld", 32'(ld_write), 32'd0);
    check("rst_pp", 32'(pp_src), 32'd0);
    check("rst_grant", 32'(grant_id), 32'd0);
    check("rst_cnt", 32'(frame_cnt), 32'd0);
    rst_n = 1'b1;
    step();
    check("empty_idle", 32'(busy), 32'd0);

    // Only adc0 non-empty.
    em_src = 5'b10111;
    frame(3, 1);
    em_src = 5'h1F;
    step();
    check("drained_idle", 32'(busy), 32'd0);

    // Only din non-empty.
    em_src = 5'b01111;
    frame(4, 2);
    em_src = 5'h1F;
    step();

    // All five requesting: strict rotation starting after the last grant (4).
    em_src = 5'h00;
    for (int f = 0; f < 7; f++) frame(f % 5, 3 + f);

    // Stall in HDR for 10 cycles.
    step();
    check("stall_grant", 32'(grant_id), 32'd2);
    tx_full = 1'b1;
    step();
    for (int c = 0; c < 10; c++) begin
      check("stall_ld", 32'(ld_write), 32'd0);
      check("stall_out", 32'(out_write), 32'h41);
      check("stall_pp", 32'(pp_src), 32'd0);
      check("stall_busy", 32'(busy), 32'd1);
      step();
    end
    check("stall_hdr_pending", 32'(out_write), 32'h41);
    tx_full = 1'b0;
    #1;
    check("resume_hdr_ld", 32'(ld_write), 32'd1);
    step();
    check("resume_low", 32'(out_write), 32'h23);
    check("resume_low_ld", 32'(ld_write), 32'd1);
    step();
    check("resume_cnt", 32'(frame_cnt), 32'd10);

    // Only adc1 enabled; drop en during LOW of the second frame.
    mask = 5'b00100;
    frame(2, 11);
    step();
    check("mask_grant", 32'(grant_id), 32'd2);
    check("mask_pp", 32'(pp_src), 32'b00100);
    step();
    step();
    en = 1'b0;
    check("en_drop_low", 32'(out_write), 32'h23);
    check("en_drop_ld", 32'(ld_write), 32'd1);
    step();
    check("en_drop_cnt", 32'(frame_cnt), 32'd12);
    for (int c = 0; c < 3; c++) begin
      step();
      check("en_off_busy", 32'(busy), 32'd0);
      check("en_off_pp", 32'(pp_src), 32'd0);
    end

    // Frame counter wrap (4-bit here).
    en   = 1'b1;
    mask = 5'h1F;
    frame(3, 13);
    frame(4, 14);
    frame(0, 15);
    frame(1, 0);

    // Asynchronous reset while in HDR.
    step();
    step();
    check("pre_rst_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_out", 32'(out_write), 32'd0);
    check("arst_ld", 32'(ld_write), 32'd0);
    check("arst_grant", 32'(grant_id), 32'd0);
    check("arst_cnt", 32'(frame_cnt), 32'd0);
    step();
    rst_n = 1'b1;
    frame(0, 1);
    frame(1, 2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
